// File: rtl/instr_encoder_if.sv
// Bundles the byte-stream input, operand fields and result handshake of instr_encoder.
// The master drives mnemonic bytes and operand fields; the slave is the encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [4:0]  f_sa;
    logic [15:0] f_imm;
    logic [25:0] f_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_byte, f_rs, f_rt, f_rd, f_sa, f_imm, f_target, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_byte, f_rs, f_rt, f_rd, f_sa, f_imm, f_target, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// Debug-side MIPS32 assembler: gathers an ASCII mnemonic byte by byte, then merges it
// with the operand fields captured alongside the terminator into one instruction word.
//
// state   | meaning
// COLLECT | accepting mnemonic bytes until the terminator
// ENCODE  | table lookup of the buffered mnemonic, result registered
// OUT     | result presented, held until out_ready
module instr_encoder #(
    parameter int         MAX_CHARS = 8,
    parameter logic [7:0] TERM_CHAR = 8'h0A
) (
    input  logic          clk,
    input  logic          resetn,
    instr_encoder_if.slave bus
);
    localparam int BW = 8 * MAX_CHARS;
    localparam int KW = (BW > 64) ? BW : 64;
    localparam int CW = $clog2(MAX_CHARS + 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ENCODE  = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [4:0]    rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, sa_q, sa_d;
    logic [15:0]   imm_q, imm_d;
    logic [25:0]   target_q, target_d;
    logic [31:0]   out_instr_q, out_instr_d;
    logic          out_err_q, out_err_d;
    logic [7:0]    char_up;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa,
                                           input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, sa, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Returns {err, instr}; the key is the buffer right-aligned exactly like a string literal.
    function automatic logic [32:0] lookup(input logic [KW-1:0] key,
                                           input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa,
                                           input logic [15:0] imm, input logic [25:0] tgt);
        logic [32:0] res;
        res = {1'b0, 32'h0};
        case (key)
            KW'("AND"):     res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h24);
            KW'("OR"):      res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h25);
            KW'("XOR"):     res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h26);
            KW'("NOR"):     res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h27);
            KW'("ADD"):     res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h20);
            KW'("ADDU"):    res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h21);
            KW'("SUB"):     res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h22);
            KW'("SUBU"):    res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h23);
            KW'("SLT"):     res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h2A);
            KW'("SLTU"):    res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h2B);
            KW'("SLLV"):    res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h04);
            KW'("SRLV"):    res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h06);
            KW'("SRAV"):    res[31:0] = r_word(rs, rt, rd, 5'd0, 6'h07);
            KW'("SLL"):     res[31:0] = r_word(5'd0, rt, rd, sa, 6'h00);
            KW'("SRL"):     res[31:0] = r_word(5'd0, rt, rd, sa, 6'h02);
            KW'("SRA"):     res[31:0] = r_word(5'd0, rt, rd, sa, 6'h03);
            KW'("MULT"):    res[31:0] = r_word(rs, rt, 5'd0, 5'd0, 6'h18);
            KW'("MULTU"):   res[31:0] = r_word(rs, rt, 5'd0, 5'd0, 6'h19);
            KW'("DIV"):     res[31:0] = r_word(rs, rt, 5'd0, 5'd0, 6'h1A);
            KW'("DIVU"):    res[31:0] = r_word(rs, rt, 5'd0, 5'd0, 6'h1B);
            KW'("MFHI"):    res[31:0] = r_word(5'd0, 5'd0, rd, 5'd0, 6'h10);
            KW'("MFLO"):    res[31:0] = r_word(5'd0, 5'd0, rd, 5'd0, 6'h12);
            KW'("MTHI"):    res[31:0] = r_word(rs, 5'd0, 5'd0, 5'd0, 6'h11);
            KW'("MTLO"):    res[31:0] = r_word(rs, 5'd0, 5'd0, 5'd0, 6'h13);
            KW'("JR"):      res[31:0] = r_word(rs, 5'd0, 5'd0, 5'd0, 6'h08);
            KW'("JALR"):    res[31:0] = r_word(rs, 5'd0, rd, 5'd0, 6'h09);
            KW'("ADDI"):    res[31:0] = i_word(6'h08, rs, rt, imm);
            KW'("ADDIU"):   res[31:0] = i_word(6'h09, rs, rt, imm);
            KW'("SLTI"):    res[31:0] = i_word(6'h0A, rs, rt, imm);
            KW'("SLTIU"):   res[31:0] = i_word(6'h0B, rs, rt, imm);
            KW'("ANDI"):    res[31:0] = i_word(6'h0C, rs, rt, imm);
            KW'("ORI"):     res[31:0] = i_word(6'h0D, rs, rt, imm);
            KW'("XORI"):    res[31:0] = i_word(6'h0E, rs, rt, imm);
            KW'("LUI"):     res[31:0] = i_word(6'h0F, 5'd0, rt, imm);
            KW'("LB"):      res[31:0] = i_word(6'h20, rs, rt, imm);
            KW'("LH"):      res[31:0] = i_word(6'h21, rs, rt, imm);
            KW'("LW"):      res[31:0] = i_word(6'h23, rs, rt, imm);
            KW'("LBU"):     res[31:0] = i_word(6'h24, rs, rt, imm);
            KW'("LHU"):     res[31:0] = i_word(6'h25, rs, rt, imm);
            KW'("SB"):      res[31:0] = i_word(6'h28, rs, rt, imm);
            KW'("SH"):      res[31:0] = i_word(6'h29, rs, rt, imm);
            KW'("SW"):      res[31:0] = i_word(6'h2B, rs, rt, imm);
            KW'("BEQ"):     res[31:0] = i_word(6'h04, rs, rt, imm);
            KW'("BNE"):     res[31:0] = i_word(6'h05, rs, rt, imm);
            KW'("BLEZ"):    res[31:0] = i_word(6'h06, rs, 5'd0, imm);
            KW'("BGTZ"):    res[31:0] = i_word(6'h07, rs, 5'd0, imm);
            KW'("BLTZ"):    res[31:0] = i_word(6'h01, rs, 5'b00000, imm);
            KW'("BGEZ"):    res[31:0] = i_word(6'h01, rs, 5'b00001, imm);
            KW'("BLTZAL"):  res[31:0] = i_word(6'h01, rs, 5'b10000, imm);
            KW'("BGEZAL"):  res[31:0] = i_word(6'h01, rs, 5'b10001, imm);
            KW'("J"):       res[31:0] = {6'h02, tgt};
            KW'("JAL"):     res[31:0] = {6'h03, tgt};
            KW'("NOP"):     res[31:0] = 32'h0000_0000;
            KW'("SYSCALL"): res[31:0] = 32'h0000_000C;
            KW'("BREAK"):   res[31:0] = 32'h0000_000D;
            KW'("ERET"):    res[31:0] = 32'h4200_0018;
            KW'("MFC0"):    res[31:0] = {6'h10, 5'b00000, rt, rd, 11'd0};
            KW'("MTC0"):    res[31:0] = {6'h10, 5'b00100, rt, rd, 11'd0};
            default:        res = {1'b1, 32'h0};
        endcase
        return res;
    endfunction

    assign char_up = (bus.in_byte >= 8'h61 && bus.in_byte <= 8'h7A) ?
                     (bus.in_byte - 8'h20) : bus.in_byte;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        sa_d        = sa_q;
        imm_d       = imm_q;
        target_d    = target_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        case (state_q)
            COLLECT: begin
                if (bus.in_valid) begin
                    if (bus.in_byte == TERM_CHAR) begin
                        // A bare terminator carries no mnemonic and is silently consumed.
                        if (cnt_q != '0) begin
                            rs_d     = bus.f_rs;
                            rt_d     = bus.f_rt;
                            rd_d     = bus.f_rd;
                            sa_d     = bus.f_sa;
                            imm_d    = bus.f_imm;
                            target_d = bus.f_target;
                            state_d  = ENCODE;
                        end
                    end else if (cnt_q == CW'(MAX_CHARS)) begin
                        ovf_d = 1'b1;
                    end else begin
                        buf_d = {buf_q[BW-9:0], char_up};
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ENCODE: begin
                if (ovf_q) begin
                    {out_err_d, out_instr_d} = {1'b1, 32'h0};
                end else begin
                    {out_err_d, out_instr_d} = lookup(KW'(buf_q), rs_q, rt_q, rd_q, sa_q,
                                                      imm_q, target_q);
                end
                state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= COLLECT;
            buf_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            sa_q        <= '0;
            imm_q       <= '0;
            target_q    <= '0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            sa_q        <= sa_d;
            imm_q       <= imm_d;
            target_q    <= target_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_instr = out_instr_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected beats are queued as mnemonics are sent and
// checked by a monitor as the encoder hands them over.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    instr_encoder_if bus ();

    instr_encoder #(.MAX_CHARS(8), .TERM_CHAR(8'h0A)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every completed output handshake pops one expectation.
    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {bus.out_err, bus.out_instr}, 33'h1_DEAD_BEEF);
            end else begin
                check(tag_q.pop_front(), {bus.out_err, bus.out_instr}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        for (int i = 0; i < 200 && !done; i++) begin
            done = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!done) check("in_ready_timeout", 33'd0, 33'd1);
    endtask

    task automatic set_fields(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [4:0] sa, input logic [15:0] imm,
                              input logic [25:0] tgt);
        bus.f_rs = rs; bus.f_rt = rt; bus.f_rd = rd;
        bus.f_sa = sa; bus.f_imm = imm; bus.f_target = tgt;
    endtask

    task automatic send(input string s, input logic exp_err, input logic [31:0] exp_instr);
        for (int i = 0; i < s.len(); i++) put_byte(s[i]);
        exp_q.push_back({exp_err, exp_instr});
        tag_q.push_back(s);
        put_byte(8'h0A);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check("drain_empty", 33'(exp_q.size()), 33'd0);
    endtask

    initial begin
        logic [31:0] held;
        bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.out_ready = 1'b1;
        set_fields(0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("reset_outputs", {bus.out_valid, bus.in_ready, bus.out_err, bus.out_instr[29:0]},
              {1'b0, 1'b1, 1'b0, 30'd0});
        resetn = 1'b1;
        tick();

        // Latency: ENCODE cycle after the terminator edge, then OUT.
        set_fields(5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        send("ADDU", 1'b0, 32'h0022_1821);
        check("lat_encode", 33'(bus.out_valid), 33'd0);
        tick();
        check("lat_out", 33'(bus.out_valid), 33'd1);
        drain();

        set_fields(5'd5, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0);
        send("lui", 1'b0, 32'h3C08_1234);
        set_fields(5'd4, 5'd7, 5'd0, 5'd0, 16'hFFFE, 26'h0);
        send("BGEZAL", 1'b0, 32'h0491_FFFE);
        set_fields(5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
        send("J", 1'b0, 32'h0810_0000);
        send("SYSCALLX", 1'b1, 32'h0);
        send("ABCDEFGHI", 1'b1, 32'h0);
        send("SYSCALL", 1'b0, 32'h0000_000C);
        send("eret", 1'b0, 32'h4200_0018);
        set_fields(5'd31, 5'd9, 5'd10, 5'd4, 16'h0, 26'h0);
        send("sll", 1'b0, 32'h0009_5100);
        set_fields(5'd29, 5'd31, 5'd0, 5'd0, 16'h0010, 26'h0);
        send("SW", 1'b0, 32'hAFBF_0010);
        set_fields(5'd3, 5'd12, 5'd14, 5'd0, 16'h0, 26'h0);
        send("MTC0", 1'b0, 32'h408C_7000);
        set_fields(5'd31, 5'd5, 5'd1, 5'd0, 16'h0, 26'h0);
        send("JALR", 1'b0, 32'h03E0_0809);
        set_fields(5'd3, 5'd7, 5'd0, 5'd0, 16'h0004, 26'h0);
        send("BGTZ", 1'b0, 32'h1C60_0004);
        set_fields(5'd4, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
        send("MULT", 1'b0, 32'h0085_0018);
        drain();

        // Backpressure: output held, stray byte not consumed.
        bus.out_ready = 1'b0;
        set_fields(5'd9, 5'd9, 5'd2, 5'd9, 16'hFFFF, 26'h0);
        send("MFLO", 1'b0, 32'h0000_1012);
        bus.in_valid = 1'b1; bus.in_byte = "X";
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        held = bus.out_instr;
        check("hold_first", {bus.out_err, held}, {1'b0, 32'h0000_1012});
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_stable", {bus.out_valid, bus.in_ready, bus.out_instr[30:0]},
                  {1'b1, 1'b0, held[30:0]});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        set_fields(5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        send("NOR", 1'b0, 32'h0022_1827);
        drain();

        // Lone terminator: nothing emitted.
        put_byte(8'h0A);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin tick(); seen |= bus.out_valid; end
            check("lone_term_silent", 33'(seen), 33'd0);
        end

        // Reset mid-mnemonic discards "AD".
        put_byte("A"); put_byte("D");
        resetn = 1'b0;
        tick(); tick();
        check("mid_reset_outputs", {bus.out_valid, bus.in_ready, bus.out_err, bus.out_instr[29:0]},
              {1'b0, 1'b1, 1'b0, 30'd0});
        resetn = 1'b1;
        tick();
        send("D", 1'b1, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
